// File: rtl/grostl_pkg.sv
// Shared constants and types for the Groestl-256 column sequencer.
// Optional build macro used by the sequencer: GROSTL_PQ_INTERLEAVE_EN.
package grostl_pkg;

  localparam int GROSTL_ROUNDS = 10;
  localparam int GROSTL_COLS   = 8;
  localparam int RND_W         = $clog2(GROSTL_ROUNDS);
  localparam int COL_W         = $clog2(GROSTL_COLS);

  localparam logic [RND_W-1:0] RND_LAST = RND_W'(GROSTL_ROUNDS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GROSTL_COLS - 1);

  typedef enum logic {
    PERM_P = 1'b0,
    PERM_Q = 1'b1
  } perm_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic             vld;
    perm_t            perm;
    logic [RND_W-1:0] rnd;
    logic [COL_W-1:0] col;
  } col_tag_t;

  // True for the writeback of the final column of the final round of Q.
  function automatic logic is_last_tag(col_tag_t t);
    return t.vld && (t.perm == PERM_Q) && (t.col == COL_LAST) && (t.rnd == RND_LAST);
  endfunction

endpackage

// File: rtl/grostl_tag_delay.sv
// PIPE-deep shift register carrying issue tags to the writeback side.
// Shifts every cycle; asynchronous clear empties the whole line.
module grostl_tag_delay
  import grostl_pkg::*;
#(
  parameter int PIPE = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  col_tag_t i_tag,
  output col_tag_t o_tag
);

  for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
    col_tag_t w_in;
    col_tag_t r_tag;

    if (gi == 0) begin : g_first
      assign w_in = i_tag;
    end else begin : g_next
      assign w_in = g_stage[gi-1].r_tag;
    end

    // One stage of the delay line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tag <= '0;
      end else begin
        r_tag <= w_in;
      end
    end
  end

  assign o_tag = g_stage[PIPE-1].r_tag;

endmodule

// File: rtl/grostl_round_ctrl.sv
// Round/column sequencer for the 64-bit Groestl datapath.
// Issues one column per cycle, drains the datapath PIPE cycles at every
// round boundary and produces writeback strobes delayed by PIPE cycles.
// Build macro GROSTL_PQ_INTERLEAVE_EN: when defined, P and Q columns of a
// round are issued back-to-back and share one drain; otherwise all P rounds
// run before all Q rounds.
module grostl_round_ctrl
  import grostl_pkg::*;
#(
  parameter int PIPE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             iss_vld,
  output logic             iss_perm,
  output logic [RND_W-1:0] iss_rnd,
  output logic [COL_W-1:0] iss_col,
  output logic             wb_vld,
  output logic             wb_perm,
  output logic [COL_W-1:0] wb_col,
  output logic             last_wb
);

  localparam int CNT_W = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE - 1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_next;
  perm_t            r_perm;
  perm_t            w_perm_next;
  logic [RND_W-1:0] r_rnd;
  logic [RND_W-1:0] w_rnd_next;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  col_tag_t         w_iss_tag;
  col_tag_t         w_wb_tag;

  // State, index and drain-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_perm  <= PERM_P;
      r_rnd   <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_perm  <= w_perm_next;
      r_rnd   <= w_rnd_next;
      r_col   <= w_col_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and index sequencing.
  always_comb begin
    w_state_next = r_state;
    w_perm_next  = r_perm;
    w_rnd_next   = r_rnd;
    w_col_next   = r_col;
    w_cnt_next   = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_ISSUE;
          w_perm_next  = PERM_P;
          w_rnd_next   = '0;
          w_col_next   = '0;
        end
      end

      ST_ISSUE: begin
        if (r_col == COL_LAST) begin
          w_col_next = '0;
`ifdef GROSTL_PQ_INTERLEAVE_EN
          // P half of the round done: continue straight into Q, no drain.
          if (r_perm == PERM_P) begin
            w_perm_next = PERM_Q;
          end else begin
            w_state_next = ST_DRAIN;
            w_cnt_next   = CNT_LOAD;
          end
`else
          w_state_next = ST_DRAIN;
          w_cnt_next   = CNT_LOAD;
`endif
        end else begin
          w_col_next = r_col + COL_W'(1);
        end
      end

      ST_DRAIN: begin
        if (r_cnt == '0) begin
`ifdef GROSTL_PQ_INTERLEAVE_EN
          w_perm_next = PERM_P;
          if (r_rnd == RND_LAST) begin
            w_rnd_next   = '0;
            w_state_next = ST_FIN;
          end else begin
            w_rnd_next   = r_rnd + RND_W'(1);
            w_state_next = ST_ISSUE;
          end
`else
          if (r_rnd == RND_LAST) begin
            w_rnd_next = '0;
            if (r_perm == PERM_Q) begin
              w_perm_next  = PERM_P;
              w_state_next = ST_FIN;
            end else begin
              w_perm_next  = PERM_Q;
              w_state_next = ST_ISSUE;
            end
          end else begin
            w_rnd_next   = r_rnd + RND_W'(1);
            w_state_next = ST_ISSUE;
          end
`endif
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      ST_FIN: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign iss_vld  = (r_state == ST_ISSUE);
  assign busy     = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign done     = (r_state == ST_FIN);
  assign iss_perm = r_perm;
  assign iss_rnd  = r_rnd;
  assign iss_col  = r_col;

  assign w_iss_tag = '{vld: iss_vld, perm: r_perm, rnd: r_rnd, col: r_col};

  grostl_tag_delay #(
    .PIPE (PIPE)
  ) u_tag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_iss_tag),
    .o_tag (w_wb_tag)
  );

  assign wb_vld  = w_wb_tag.vld;
  assign wb_perm = w_wb_tag.perm;
  assign wb_col  = w_wb_tag.col;
  assign last_wb = is_last_tag(w_wb_tag);

endmodule

// File: tb/tb_grostl_round_ctrl.sv
// Bench for grostl_round_ctrl: three instances (PIPE = 1, 2, 4) driven by
// shared start/reset, checked each cycle against a timing model computed
// from the cycle offset within a run. Honours GROSTL_PQ_INTERLEAVE_EN.
module tb_grostl_round_ctrl;
  import grostl_pkg::*;

  localparam int NI = 3;
  localparam int R  = GROSTL_ROUNDS;
  localparam int C  = GROSTL_COLS;
`ifdef GROSTL_PQ_INTERLEAVE_EN
  localparam bit ILV = 1'b1;
`else
  localparam bit ILV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  logic             busy_a    [NI];
  logic             done_a    [NI];
  logic             iss_vld_a [NI];
  logic             iss_perm_a[NI];
  logic [RND_W-1:0] iss_rnd_a [NI];
  logic [COL_W-1:0] iss_col_a [NI];
  logic             wb_vld_a  [NI];
  logic             wb_perm_a [NI];
  logic [COL_W-1:0] wb_col_a  [NI];
  logic             last_wb_a [NI];

  int checks = 0;
  int errors = 0;
  int m_k      [NI] = '{-1, -1, -1};
  int busy_cnt [NI] = '{0, 0, 0};
  int vld_cnt  [NI] = '{0, 0, 0};
  int done_cnt [NI] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int P = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    grostl_round_ctrl #(.PIPE(P)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy_a[gi]),
      .done     (done_a[gi]),
      .iss_vld  (iss_vld_a[gi]),
      .iss_perm (iss_perm_a[gi]),
      .iss_rnd  (iss_rnd_a[gi]),
      .iss_col  (iss_col_a[gi]),
      .wb_vld   (wb_vld_a[gi]),
      .wb_perm  (wb_perm_a[gi]),
      .wb_col   (wb_col_a[gi]),
      .last_wb  (last_wb_a[gi])
    );
  end

  typedef struct {
    bit vld;
    int perm;
    int rnd;
    int col;
  } exp_t;

  function automatic int pipe_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic int total_of(int p);
    return ILV ? R * (2 * C + p) : 2 * R * (C + p);
  endfunction

  // Hand-computed busy lengths for PIPE = 1, 2, 4.
  function automatic int lit_busy(int i);
    if (ILV) return (i == 0) ? 170 : ((i == 1) ? 180 : 200);
    return (i == 0) ? 180 : ((i == 1) ? 200 : 240);
  endfunction

  // What is issued k cycles after the first busy cycle of a run.
  function automatic exp_t exp_iss(int k, int p);
    exp_t e;
    int g, o, grp;
    e = '{vld: 1'b0, perm: 0, rnd: 0, col: 0};
    if (k < 0 || k >= total_of(p)) return e;
    grp = ILV ? 2 * C : C;
    g = k / (grp + p);
    o = k % (grp + p);
    if (o < grp) begin
      e.vld = 1'b1;
      if (ILV) begin
        e.rnd = g; e.perm = o / C; e.col = o % C;
      end else begin
        e.perm = g / R; e.rnd = g % R; e.col = o;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d k=%0d t=%0t got=%0d want=%0d", nm, i, m_k[i], $time, act, exp);
    end
  endtask

  // Run-offset model: -1 idle, otherwise cycles since the first busy cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) m_k[i] <= -1;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_k[i] < 0) begin
          if (start) m_k[i] <= 0;
        end else if (m_k[i] >= total_of(pipe_of(i))) begin
          m_k[i] <= -1;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int k, p;
      exp_t ei, ew;
      bit elast;
      k  = m_k[i];
      p  = pipe_of(i);
      ei = exp_iss(k, p);
      ew = (k >= 0) ? exp_iss(k - p, p) : exp_iss(-1, p);
      elast = ew.vld && ew.perm == 1 && ew.col == C - 1 && ew.rnd == R - 1;
      chk("busy", i, int'(busy_a[i]), int'(k >= 0 && k < total_of(p)));
      chk("done", i, int'(done_a[i]), int'(k == total_of(p)));
      chk("iss_vld", i, int'(iss_vld_a[i]), int'(ei.vld));
      chk("wb_vld", i, int'(wb_vld_a[i]), int'(ew.vld));
      chk("last_wb", i, int'(last_wb_a[i]), int'(elast));
      if (ei.vld) begin
        chk("iss_perm", i, int'(iss_perm_a[i]), ei.perm);
        chk("iss_rnd", i, int'(iss_rnd_a[i]), ei.rnd);
        chk("iss_col", i, int'(iss_col_a[i]), ei.col);
      end
      if (ew.vld) begin
        chk("wb_perm", i, int'(wb_perm_a[i]), ew.perm);
        chk("wb_col", i, int'(wb_col_a[i]), ew.col);
      end
      busy_cnt[i] += int'(busy_a[i]);
      vld_cnt[i]  += int'(iss_vld_a[i]);
      done_cnt[i] += int'(done_a[i]);
    end
  end

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = (m_k[0] < 0) && (m_k[1] < 0) && (m_k[2] < 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout waiting for idle", nm);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    for (int i = 0; i < NI; i++) begin
      chk({nm, "_busy"}, i, int'(busy_a[i]), 0);
      chk({nm, "_done"}, i, int'(done_a[i]), 0);
      chk({nm, "_iss_vld"}, i, int'(iss_vld_a[i]), 0);
      chk({nm, "_wb_vld"}, i, int'(wb_vld_a[i]), 0);
      chk({nm, "_last_wb"}, i, int'(last_wb_a[i]), 0);
      chk({nm, "_idx"}, i, int'({iss_perm_a[i], iss_rnd_a[i], iss_col_a[i]}), 0);
    end
  endtask

  int b0[NI], v0[NI], d0[NI];

  task automatic snap();
    for (int i = 0; i < NI; i++) begin
      b0[i] = busy_cnt[i]; v0[i] = vld_cnt[i]; d0[i] = done_cnt[i];
    end
  endtask

  task automatic chk_run(input string nm);
    for (int i = 0; i < NI; i++) begin
      chk({nm, "_busy_len"}, i, busy_cnt[i] - b0[i], lit_busy(i));
      chk({nm, "_iss_cnt"}, i, vld_cnt[i] - v0[i], 160);
      chk({nm, "_done_cnt"}, i, done_cnt[i] - d0[i], 1);
      $display("run %s inst=%0d pipe=%0d busy=%0d issues=%0d dones=%0d", nm, i, pipe_of(i),
               busy_cnt[i] - b0[i], vld_cnt[i] - v0[i], done_cnt[i] - d0[i]);
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1/2/3: single full run with literal pins on PIPE=2 instance.
    snap();
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t1_busy", 1, int'(busy_a[1]), 1);
      if (t < 8) begin
        chk("t1_iss_vld", 1, int'(iss_vld_a[1]), 1);
        chk("t1_iss_col", 1, int'(iss_col_a[1]), t);
        chk("t1_iss_pr", 1, int'({iss_perm_a[1], iss_rnd_a[1]}), 0);
      end
      if (t == 8) chk("t1_grp_end", 1, int'({iss_vld_a[1], iss_perm_a[1]}), ILV ? 3 : 0);
      if (t >= 2 && t < 10) begin
        chk("t1_wb_vld", 1, int'(wb_vld_a[1]), 1);
        chk("t1_wb_col", 1, int'(wb_col_a[1]), t - 2);
        chk("t1_wb_perm", 1, int'(wb_perm_a[1]), 0);
      end
      if (t < 2) chk("t1_wb_lag", 1, int'(wb_vld_a[1]), 0);
    end
    wait_idle("t2");
    chk_run("full");

    // Test 4: start held high -> one run, restart only after an IDLE cycle.
    snap();
    @(negedge clk);
    start = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = done_a[1];
    end
    chk("t4_done_seen", 1, int'(seen), 1);
    chk("t4_one_run", 1, busy_cnt[1] - b0[1], lit_busy(1));
    @(negedge clk);
    chk("t4_idle_gap", 1, int'(busy_a[1]), 0);
    @(negedge clk);
    chk("t4_restart", 1, int'(busy_a[1]), 1);
    start = 1'b0;
    wait_idle("t4");

    // Test 5: asynchronous reset in round 4, column 3 of the PIPE=2 instance.
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      seen = (m_k[1] == (ILV ? 75 : 43));
      if (!seen) @(negedge clk);
    end
    chk("t5_reach", 1, int'(seen), 1);
    chk("t5_rnd", 1, int'(iss_rnd_a[1]), 4);
    chk("t5_col", 1, int'(iss_col_a[1]), 3);
    snap();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t5_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("t5_no_done", i, done_cnt[i] - d0[i], 0);
    snap();
    pulse_start();
    wait_idle("t5");
    chk_run("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
